pc_sequencer: RTL and testbench

Owns the fetch program counter of the RISC-V core and sequences instruction fetch. It consumes the 2-bit PC-select decision that branch control resolves in EX and redirects the PC: sequential, branch/JAL target, JALR target, or trap. It also drives the instruction-memory request/ready handshake, flushes younger pipeline stages on redirect, and implements ECALL trap entry and EBREAK halt/resume.

---
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch program counter and instruction-fetch sequencer: redirects, ECALL trap entry, EBREAK halt/resume.
// Optional build macro PC_MISALIGN_TRAP_EN turns misaligned redirect targets into traps.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] ex_pc,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic        ebreak,
    input  logic        stall,
    input  logic        resume,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic        flush,
    output logic        fetch_kill,
    output logic        trap_taken,
    output logic [31:0] mepc,
    output logic        halted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]  state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] mepc_r, mepc_s;
    logic [31:0] pend_pc_r, pend_pc_s;
    logic        pend_valid_r, pend_valid_s;
    logic        trap_taken_r, trap_taken_s;
    logic        halted_r;
    logic        redirect_s, is_ebreak_s, is_trap_s, misalign_s;
    logic [31:0] raw_target_s, target_s;

    // Raw redirect target selected by the EX-stage decision
    always_comb begin
        raw_target_s = TRAP_PC;
        case (pc_sel)
            2'b10:   raw_target_s = br_target;
            2'b01:   raw_target_s = jalr_target & ~32'h0000_0001;
            default: raw_target_s = TRAP_PC;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_s = (pc_sel != 2'b11) && (raw_target_s[1:0] != 2'b00);
    assign target_s   = misalign_s ? TRAP_PC : raw_target_s;
`else
    assign misalign_s = 1'b0;
    assign target_s   = {raw_target_s[31:2], 2'b00};
`endif

    // Redirects are only acted on while fetching; HALT and DRAIN ignore them
    assign redirect_s  = ex_valid && (pc_sel != 2'b00) && (state_r == ST_FETCH);
    assign is_ebreak_s = redirect_s && (pc_sel == 2'b11) && ebreak;
    assign is_trap_s   = redirect_s && (((pc_sel == 2'b11) && !ebreak) || misalign_s);

    assign flush      = redirect_s;
    assign imem_req   = (state_r == ST_FETCH) || (state_r == ST_DRAIN);
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign mepc       = mepc_r;
    assign trap_taken = trap_taken_r;
    assign halted     = halted_r;
    // A fresh redirect on the completing cycle supersedes the pending one; flush covers that case
    assign fetch_kill = ((state_r == ST_FETCH) && pend_valid_r && imem_ready && !redirect_s)
                      || ((state_r == ST_DRAIN) && imem_ready);

    // Next-state and next-PC decision
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        mepc_s       = mepc_r;
        pend_pc_s    = pend_pc_r;
        pend_valid_s = pend_valid_r;
        trap_taken_s = 1'b0;
        case (state_r)
            ST_IDLE: state_s = ST_FETCH;
            ST_FETCH: begin
                if (is_ebreak_s) begin
                    mepc_s       = ex_pc;
                    pend_valid_s = 1'b0;
                    if (imem_ready) begin
                        state_s = ST_HALT;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (redirect_s) begin
                    if (is_trap_s) begin
                        mepc_s       = ex_pc;
                        trap_taken_s = 1'b1;
                    end else begin
                        mepc_s = mepc_r;
                    end
                    if (imem_ready) begin
                        pc_s         = target_s;
                        pend_valid_s = 1'b0;
                    end else begin
                        pend_pc_s    = target_s;
                        pend_valid_s = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (pend_valid_r) begin
                        pc_s         = pend_pc_r;
                        pend_valid_s = 1'b0;
                    end else if (!stall) begin
                        pc_s = pc_r + 32'd4;
                    end else begin
                        pc_s = pc_r;
                    end
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_DRAIN: begin
                if (imem_ready) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    pc_s    = mepc_r + 32'd4;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            mepc_r       <= 32'h0000_0000;
            pend_pc_r    <= 32'h0000_0000;
            pend_valid_r <= 1'b0;
            trap_taken_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            mepc_r       <= mepc_s;
            pend_pc_r    <= pend_pc_s;
            pend_valid_r <= pend_valid_s;
            trap_taken_r <= trap_taken_s;
            halted_r     <= (state_s == ST_HALT);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations are hand-computed per step.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  pc_sel;
    logic [31:0] ex_pc;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic        ebreak;
    logic        stall;
    logic        resume;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        flush;
    logic        fetch_kill;
    logic        trap_taken;
    logic [31:0] mepc;
    logic        halted;

    int checks = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pc_sel(pc_sel), .ex_pc(ex_pc),
        .br_target(br_target), .jalr_target(jalr_target), .ebreak(ebreak), .stall(stall),
        .resume(resume), .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .pc(pc), .flush(flush), .fetch_kill(fetch_kill), .trap_taken(trap_taken),
        .mepc(mepc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] sel, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        pc_sel    = sel;
        br_target = tgt;
        jalr_target = tgt;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; pc_sel = 2'b00; ex_pc = 32'h0; br_target = 32'h0;
        jalr_target = 32'h0; ebreak = 1'b0; stall = 1'b0; resume = 1'b0; imem_ready = 1'b1;
        #12;
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_mepc", mepc, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_kill", {31'd0, fetch_kill}, 32'd0);
        chk("rst_trap", {31'd0, trap_taken}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // release: one IDLE cycle, then sequential fetch 0,4,8
        step(); rst_n = 1'b1; #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("addr0", imem_addr, 32'h0);
        step(); chk("addr4", imem_addr, 32'h4);
        step(); chk("addr8", imem_addr, 32'h8);

        // taken branch with ready
        redir(2'b10, 32'h100); #1;
        chk("br_flush", {31'd0, flush}, 32'd1);
        chk("br_nokill", {31'd0, fetch_kill}, 32'd0);
        step(); ex_valid = 1'b0; #1;
        chk("br_pc", pc, 32'h100);
        chk("br_flush_off", {31'd0, flush}, 32'd0);

        // branch while not ready: pending until the ready cycle
        imem_ready = 1'b0; redir(2'b10, 32'h180); #1;
        chk("pend_flush", {31'd0, flush}, 32'd1);
        step(); ex_valid = 1'b0;
        chk("pend_hold1", pc, 32'h100);
        step(); chk("pend_hold2", imem_addr, 32'h100);
        step(); chk("pend_hold3", pc, 32'h100);
        imem_ready = 1'b1; #1;
        chk("pend_kill", {31'd0, fetch_kill}, 32'd1);
        step(); chk("pend_pc", pc, 32'h180);
        chk("pend_kill_off", {31'd0, fetch_kill}, 32'd0);

        // second redirect while pending overwrites target
        imem_ready = 1'b0; redir(2'b10, 32'h200);
        step(); redir(2'b10, 32'h240);
        step(); ex_valid = 1'b0; imem_ready = 1'b1; #1;
        chk("ovw_kill", {31'd0, fetch_kill}, 32'd1);
        step(); chk("ovw_pc", pc, 32'h240);

        // JALR clears bit 0
        redir(2'b01, 32'h205);
        step(); ex_valid = 1'b0;
        chk("jalr_pc", pc, 32'h204);

        // misaligned JALR target
        redir(2'b01, 32'h206); ex_pc = 32'h70;
        step(); ex_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_pc", pc, 32'h40);
        chk("mis_trap", {31'd0, trap_taken}, 32'd1);
        chk("mis_mepc", mepc, 32'h70);
`else
        chk("mis_pc", pc, 32'h204);
        chk("mis_trap", {31'd0, trap_taken}, 32'd0);
`endif

        // ECALL together with stall: trap wins
        redir(2'b11, 32'h0); ebreak = 1'b0; ex_pc = 32'h80; stall = 1'b1;
        step(); ex_valid = 1'b0; stall = 1'b0;
        chk("ecall_pc", pc, 32'h40);
        chk("ecall_mepc", mepc, 32'h80);
        chk("ecall_trap", {31'd0, trap_taken}, 32'd1);
        step();
        chk("ecall_trap_off", {31'd0, trap_taken}, 32'd0);
        chk("ecall_seq", pc, 32'h44);

        // stall holds PC, redirect overrides stall
        redir(2'b10, 32'h10);
        step(); ex_valid = 1'b0; stall = 1'b1;
        chk("stall_start", pc, 32'h10);
        step(); chk("stall_hold1", pc, 32'h10);
        step(); chk("stall_hold2", pc, 32'h10);
        redir(2'b10, 32'h300);
        step(); ex_valid = 1'b0; stall = 1'b0;
        chk("stall_redir", pc, 32'h300);

        // EBREAK with outstanding fetch: DRAIN then HALT
        imem_ready = 1'b0; redir(2'b11, 32'h0); ebreak = 1'b1; ex_pc = 32'h90; #1;
        chk("ebk_flush", {31'd0, flush}, 32'd1);
        step(); ex_valid = 1'b0; ebreak = 1'b0; #1;
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_nokill", {31'd0, fetch_kill}, 32'd0);
        chk("drain_halted", {31'd0, halted}, 32'd0);
        step(); imem_ready = 1'b1; #1;
        chk("drain_kill", {31'd0, fetch_kill}, 32'd1);
        step();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_mepc", mepc, 32'h90);
        redir(2'b10, 32'h500); #1;
        chk("halt_noflush", {31'd0, flush}, 32'd0);
        step(); ex_valid = 1'b0;
        chk("halt_pc", pc, 32'h300);
        chk("halt_stay", {31'd0, halted}, 32'd1);
        resume = 1'b1;
        step(); resume = 1'b0;
        chk("resume_pc", pc, 32'h94);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        step(); chk("resume_seq", pc, 32'h98);

        // resume outside HALT has no effect
        imem_ready = 1'b0; resume = 1'b1;
        step(); resume = 1'b0; imem_ready = 1'b1;
        chk("resume_ign", pc, 32'h98);

        // wrap-around
        redir(2'b10, 32'hFFFF_FFFC);
        step(); ex_valid = 1'b0;
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        step(); chk("wrap_zero", pc, 32'h0);

        // reset mid-operation drops a pending redirect
        imem_ready = 1'b0; redir(2'b10, 32'h400);
        step(); ex_valid = 1'b0; rst_n = 1'b0; #1;
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        step(); rst_n = 1'b1; imem_ready = 1'b1;
        step();
        chk("mrst_nokill", {31'd0, fetch_kill}, 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        step(); chk("mrst_seq", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
